// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//
// Clocked ALU sitting between the register-file read ports and the write-back
// mux. Single-cycle operations (add/sub/logic/compare/move) register their
// result one cycle after acceptance. Shifts and rotates run one bit position
// per cycle. Multiply runs as an unsigned shift-add over WIDTH cycles. The
// controller stalls while busy is high.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset (aborts any running operation)
//   start   request, accepted only while busy=0
//   opcode  operation select, sampled on accept
//   ina     operand A (r[Rd]), sampled on accept
//   inb     operand B (r[Rs]); shift amount is inb[SW-1:0]
//   out     registered result, holds until the next done
//   s,z,c,v registered sign/zero/carry/overflow flags, updated with done
//   wr_en   high with done when the result is to be written back
//   busy    multi-cycle operation in progress
//   done    one-cycle pulse, out/flags/wr_en valid in this cycle
// -----------------------------------------------------------------------------
module multicycle_alu #(
   parameter int WIDTH = 16,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   output logic [WIDTH-1:0] out,
   output logic             s,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic             wr_en,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_SLL = 4'd8;
   localparam logic [3:0] OP_SLR = 4'd9;
   localparam logic [3:0] OP_SRL = 4'd10;
   localparam logic [3:0] OP_SRA = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, state_nxt;
   logic [3:0]           op_q;
   logic [WIDTH-1:0]     work;       // shift/rotate working value
   logic [2*WIDTH-1:0]   mcand;      // multiplicand, shifted left each step
   logic [WIDTH-1:0]     mplier;     // multiplier, shifted right each step
   logic [2*WIDTH-1:0]   prod;       // partial product
   logic [SW:0]          cnt;        // must hold WIDTH, hence SW+1 bits

   logic [SW-1:0]        shamt;
   logic                 accept, go_run, last_step;
   logic [WIDTH:0]       sum, diff;
   logic [WIDTH-1:0]     sc_res, run_res, work_nxt;
   logic                 sc_c, sc_v, sc_we, run_c, carry_nxt;
   logic [2*WIDTH-1:0]   prod_nxt;

   assign shamt     = inb[SW-1:0];
   assign accept    = start && (state == IDLE);
   // Zero-amount shifts complete through the single-cycle path.
   assign go_run    = accept && ((opcode == OP_MUL) ||
                      ((opcode inside {OP_SLL, OP_SLR, OP_SRL, OP_SRA}) && (shamt != '0)));
   assign last_step = (state == RUN) && (cnt == (SW+1)'(1));
   assign busy      = (state == RUN);

   // SUB/CMP compute B-A; the extra top bit is the borrow.
   assign sum  = {1'b0, ina} + {1'b0, inb};
   assign diff = {1'b0, inb} - {1'b0, ina};

   // Single-cycle result, evaluated directly on the incoming operands.
   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_we  = 1'b0;
      case (opcode)
         OP_ADD: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (ina[WIDTH-1] == inb[WIDTH-1]) && (sum[WIDTH-1] != ina[WIDTH-1]);
            sc_we  = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            sc_res = diff[WIDTH-1:0];
            sc_c   = diff[WIDTH];
            sc_v   = (ina[WIDTH-1] != inb[WIDTH-1]) && (diff[WIDTH-1] != inb[WIDTH-1]);
            sc_we  = (opcode == OP_SUB);
         end
         OP_AND: begin sc_res = ina & inb; sc_we = 1'b1; end
         OP_OR:  begin sc_res = ina | inb; sc_we = 1'b1; end
         OP_XOR: begin sc_res = ina ^ inb; sc_we = 1'b1; end
         OP_MOV: begin sc_res = ina;       sc_we = 1'b1; end
         OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin sc_res = ina; sc_we = 1'b1; end
         default: ;
      endcase
   end

   // One iteration of the running operation. The carry of a shift is the bit
   // leaving the word on this step, so only the final step's value matters.
   always_comb begin
      work_nxt  = work;
      carry_nxt = 1'b0;
      prod_nxt  = prod;
      case (op_q)
         OP_SLL: begin carry_nxt = work[WIDTH-1]; work_nxt = {work[WIDTH-2:0], 1'b0}; end
         OP_SLR: work_nxt = {work[WIDTH-2:0], work[WIDTH-1]};
         OP_SRL: begin carry_nxt = work[0]; work_nxt = {1'b0, work[WIDTH-1:1]}; end
         OP_SRA: begin carry_nxt = work[0]; work_nxt = {work[WIDTH-1], work[WIDTH-1:1]}; end
         OP_MUL: if (mplier[0]) prod_nxt = prod + mcand;
         default: ;
      endcase
      run_res = (op_q == OP_MUL) ? prod_nxt[WIDTH-1:0] : work_nxt;
      run_c   = (op_q == OP_MUL) ? |prod_nxt[2*WIDTH-1:WIDTH] : carry_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (go_run)    state_nxt = RUN;
         RUN:  if (last_step) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: the datapath registers are reset along with the outputs; a reset
   // mid-operation then leaves nothing stale that could leak into a later op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= '0;
         work   <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
         out    <= '0;
         s      <= 1'b0;
         z      <= 1'b0;
         c      <= 1'b0;
         v      <= 1'b0;
         wr_en  <= 1'b0;
         done   <= 1'b0;
      end else begin
         done  <= 1'b0;
         wr_en <= 1'b0;
         if (accept) begin
            op_q   <= opcode;
            work   <= ina;
            mcand  <= {{WIDTH{1'b0}}, ina};
            mplier <= inb;
            prod   <= '0;
            cnt    <= (opcode == OP_MUL) ? (SW+1)'(WIDTH) : {1'b0, shamt};
            if (!go_run) begin
               out   <= sc_res;
               s     <= sc_res[WIDTH-1];
               z     <= (sc_res == '0);
               c     <= sc_c;
               v     <= sc_v;
               wr_en <= sc_we;
               done  <= 1'b1;
            end
         end else if (state == RUN) begin
            work   <= work_nxt;
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - (SW+1)'(1);
            if (last_step) begin
               out   <= run_res;
               s     <= run_res[WIDTH-1];
               z     <= (run_res == '0);
               c     <= run_c;
               v     <= 1'b0;
               wr_en <= 1'b1;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, clocked successor to the combinational 16-bit ALU in the simpleb datapath. It keeps the same opcode map and SZCV flag semantics for single-cycle operations. It adds multi-cycle shifts/rotates and an iterative multiply, a start/busy/done handshake, registered result and flags, and a write-enable qualifier. It sits between the register-file read ports and the write-back mux, and the controller stalls on `busy`.

## Interface
- `WIDTH`, 16, operand/result width; minimum 4, power of two.
- `SW`, $clog2(WIDTH), shift-amount width (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `opcode`  in  4  operation, sampled on accept.
- `ina`  in  WIDTH  operand A (r[Rd]), sampled on accept.
- `inb`  in  WIDTH  operand B (r[Rs]); shift amount = `inb[SW-1:0]`, upper bits ignored.
- `out`  out  WIDTH  registered result; holds until next `done`.
- `s`, `z`, `c`, `v`  out  1 each  registered flags; update only with `done`.
- `wr_en`  out  1  high with `done` when the result must be written back.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse; `out`/flags/`wr_en` valid this cycle.

## Operation
- 0 ADD: A+B. C = carry out of bit WIDTH-1. V = same-sign operands with a different-sign result.
- 1 SUB: B−A, computed WIDTH+1 wide. C = bit WIDTH (borrow). V = operand signs differ and sign(result)≠sign(B).
- 2 AND, 3 OR, 4 XOR: C=0, V=0.
- 5 CMP: same result and flags as SUB; `wr_en`=0.
- 6 MOV: result = A. C=0, V=0.
- 8 SLL (logical left), 9 SLR (rotate left), 10 SRL (logical right), 11 SRA (arithmetic right): operand A, amount n = B[SW-1:0].
  - Shifts (not rotate): C = last bit shifted out. C=0 when n=0 and for SLR. V=0.
- 12 MUL: unsigned shift-add, WIDTH iterations. Result = low WIDTH bits of A×B. C = 1 if the high WIDTH bits are nonzero. V=0.
- 7, 13–15: result 0, flags S=0 Z=1 C=0 V=0, `wr_en`=0.
- For all opcodes: S = result[WIDTH-1]; Z = (result==0).
- FSM has two states:
  - IDLE: accept when `start`=1. Single-cycle ops, and shifts with n=0, register the result directly and stay in IDLE. Shifts with n>0 load the counter with n and go to RUN. MUL loads the counter with WIDTH and goes to RUN.
  - RUN: one shift or one add-shift step per cycle, counter decrements. On the final step, register result/flags, pulse `done`, return to IDLE.
- `busy` = (state==RUN). `start` while busy is ignored; no queueing.
- Operands and opcode are latched on accept. Input changes after accept have no effect.
- Reset (any time, including mid-RUN) aborts the operation. State IDLE; `out`=0; s=z=c=v=0; `done`=`wr_en`=`busy`=0. No `done` is issued for the aborted operation.

## Timing
- Request accepted at the edge ending cycle T.
- Single-cycle ops and zero-amount shifts: `done` in T+1, `busy` never asserts.
- Shift by n>0: `busy` in T+1..T+n, `done` in T+n+1.
- MUL: `busy` in T+1..T+WIDTH, `done` in T+WIDTH+1.
- `done` and `busy` are never high together. A `start` in the `done` cycle is accepted, so single-cycle ops can issue back-to-back every cycle.
- `wr_en` is only ever high in a `done` cycle.

## Test plan
- ADD A=0x7FFF, B=0x0001 -> `done` at T+1; out=0x8000, S=1 Z=0 C=0 V=1, wr_en=1.
- SUB A=0x0001, B=0x0000 -> out=0xFFFF, S=1 C=1 V=0, wr_en=1. Repeat with CMP -> identical out/flags, wr_en=0.
- SRA A=0x8001, B=0x0004 -> busy T+1..T+4, `done` at T+5; out=0xF800, C=0, S=1. SLL A=0x8000, B=1 -> out=0, Z=1, C=1, `done` T+2.
- MUL A=0x0100, B=0x0100 -> busy 16 cycles, `done` at T+17; out=0x0000, Z=1, C=1. MUL A=0x00FF, B=0x0003 -> out=0x02FD, C=0.
- `start` pulsed during MUL busy with ADD -> ignored; no extra `done`; out and flags unchanged until MUL completes. ADD issued in the MUL `done` cycle completes in the next cycle.
- Assert `rst` in MUL cycle T+8 -> all outputs 0 immediately; no `done` after release. Opcode 7 afterwards -> out=0, Z=1, wr_en=0.
